// File: rtl/fetch_unit_if.sv
// Bundle of the fetch front end's external channels: execute redirect,
// instruction-memory request/response, and the decode-side output register.
interface fetch_unit_if;
  logic        br_en;
  logic [31:0] br_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    input  br_en,
    input  br_target,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    output br_en,
    output br_target,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );
endinterface

// File: rtl/fetch_unit.sv
// PC generator and single-outstanding instruction fetch with a one-deep
// output register to decode; redirects squash any in-flight fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_pc_reg, req_pc_next;
  logic        discard_reg, discard_next;
  logic        out_valid_reg, out_valid_next;
  logic [31:0] out_pc_reg, out_pc_next;
  logic [31:0] out_instr_reg, out_instr_next;

  logic [31:0] target;
  logic        req_fire;

  assign target   = bus.br_target & 32'hFFFF_FFFC;
  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = (state_reg == ST_REQ) && !rst;
  assign bus.imem_req_addr  = pc_reg;
  assign bus.if_valid       = out_valid_reg;
  assign bus.if_pc          = out_pc_reg;
  assign bus.if_instr       = out_instr_reg;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    req_pc_next    = req_pc_reg;
    discard_next   = discard_reg;
    out_valid_next = out_valid_reg;
    out_pc_next    = out_pc_reg;
    out_instr_next = out_instr_reg;

    case (state_reg)
      ST_REQ: begin
        if (req_fire) begin
          req_pc_next = pc_reg;
          pc_next     = pc_reg + 32'd4;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (discard_reg) begin
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end else begin
            out_valid_next = 1'b1;
            out_pc_next    = req_pc_reg;
            out_instr_next = bus.imem_rsp_data;
            state_next     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (bus.if_ready) begin
          out_valid_next = 1'b0;
          out_instr_next = NOP_INSTR;
          state_next     = ST_REQ;
        end
      end
      default: begin
        state_next = ST_REQ;
      end
    endcase

    // A redirect overrides the normal progression; only the bookkeeping for
    // a request already committed to imem survives, via the discard flag.
    if (bus.br_en) begin
      pc_next        = target;
      out_valid_next = 1'b0;
      out_instr_next = NOP_INSTR;
      case (state_reg)
        ST_REQ: begin
          if (req_fire) begin
            discard_next = 1'b1;
            state_next   = ST_WAIT;
          end else begin
            state_next = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rsp_valid) begin
            discard_next = 1'b0;
            state_next   = ST_REQ;
          end else begin
            discard_next = 1'b1;
            state_next   = ST_WAIT;
          end
        end
        default: begin
          state_next = ST_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_REQ;
      pc_reg        <= RESET_PC;
      req_pc_reg    <= 32'd0;
      discard_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
      out_pc_reg    <= 32'd0;
      out_instr_reg <= NOP_INSTR;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      req_pc_reg    <= req_pc_next;
      discard_reg   <= discard_next;
      out_valid_reg <= out_valid_next;
      out_pc_reg    <= out_pc_next;
      out_instr_reg <= out_instr_next;
    end
  end

endmodule
